// File: rtl/onewire_pkg.sv
// onewire_pkg: constants shared by the 1-Wire master transmitter and slave receiver.
// Timing values are in clk cycles. State codes are plain 2-bit constants so the
// package stays usable from legacy code that cannot import enum types.
package onewire_pkg;

  localparam int CNT_W   = 10;   // must hold RST_MIN and PD_LEN

  localparam int T1_MAX  = 15;   // longest low decoded as bit 1
  localparam int T0_MIN  = 45;   // shortest low decoded as bit 0
  localparam int T0_MAX  = 120;  // longest low decoded as bit 0
  localparam int RST_MIN = 480;  // shortest low decoded as bus reset
  localparam int PD_WAIT = 30;   // high cycles before presence drive
  localparam int PD_LEN  = 240;  // presence pulse length

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] MEAS       = 2'd1;
  localparam logic [1:0] PRES_WAIT  = 2'd2;
  localparam logic [1:0] PRES_DRIVE = 2'd3;

endpackage

// File: rtl/onewire_sync.sv
// onewire_sync: 2-FF synchronizer for the raw 1-Wire bus plus fall/rise detect.
// The stages reset low so a bus that is already low when reset releases never
// looks like a falling edge; a bus that is high only produces a harmless rise.
module onewire_sync (
  input  logic clk,
  input  logic rst,
  input  logic bus_i,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // two synchronizer stages and one history stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= bus_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign fall_o = prev_q & ~sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/onewire_slave_rx.sv
// onewire_slave_rx: 1-Wire slave receiver. Measures each low pulse on the
// synchronized bus, classifies it (bit 1 / bit 0 / bus reset / error) and
// assembles data bits LSB-first into bytes.
// Build option: define ONEWIRE_SLAVE_PRESENCE_EN to answer a bus reset with a
// presence pulse on bus_pull_low; otherwise bus_pull_low is tied low.
//
// state      | meaning
// IDLE       | bus high, waiting for a falling edge
// MEAS       | bus low, counting low width (saturates at RST_MIN)
// PRES_WAIT  | after reset, counting high cycles before presence drive
// PRES_DRIVE | driving presence low, then waiting for the bus to rise
module onewire_slave_rx
  import onewire_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_in,
  output logic       bus_pull_low,
  output logic       bit_out,
  output logic       bit_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       rst_det,
  output logic       err
);

  localparam logic [CNT_W-1:0] W_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] W_T1_MAX  = CNT_W'(T1_MAX);
  localparam logic [CNT_W-1:0] W_T0_MIN  = CNT_W'(T0_MIN);
  localparam logic [CNT_W-1:0] W_T0_MAX  = CNT_W'(T0_MAX);
  localparam logic [CNT_W-1:0] W_RST_MIN = CNT_W'(RST_MIN);

  logic bus_fall;
  logic bus_rise;

  onewire_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .bus_i  (bus_in),
    .fall_o (bus_fall),
    .rise_o (bus_rise)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Only 7 history bits are kept: the 8th bit goes straight into byte_out.
  logic [6:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             rst_det_q, rst_det_d;
  logic             err_q, err_d;

  logic is_one;
  logic is_zero;
  logic is_rst;

  assign is_one  = (cnt_q <= W_T1_MAX);
  assign is_zero = (cnt_q >= W_T0_MIN) && (cnt_q <= W_T0_MAX);
  assign is_rst  = (cnt_q >= W_RST_MIN);

`ifdef ONEWIRE_SLAVE_PRESENCE_EN
  localparam logic [CNT_W-1:0] W_PD_WAIT_M1 = CNT_W'(PD_WAIT - 1);
  localparam logic [CNT_W-1:0] W_PD_LEN     = CNT_W'(PD_LEN);
  logic pull_q, pull_d;
`endif

  // next-state, pulse classification and byte assembly
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    bit_out_d    = bit_out_q;
    bit_valid_d  = 1'b0;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    rst_det_d    = 1'b0;
    err_d        = 1'b0;
`ifdef ONEWIRE_SLAVE_PRESENCE_EN
    pull_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus_fall) begin
          state_d = MEAS;
          cnt_d   = W_ONE;
        end
      end
      MEAS: begin
        // MEAS is only entered on a fall, so the first high sample is a rise
        if (bus_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (is_one || is_zero) begin
            bit_out_d   = is_one;
            bit_valid_d = 1'b1;
            shift_d     = {is_one, shift_q[6:1]};
            idx_d       = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              byte_out_d   = {is_one, shift_q};
              byte_valid_d = 1'b1;
            end
          end else if (is_rst) begin
            rst_det_d = 1'b1;
            idx_d     = '0;
            shift_d   = '0;
`ifdef ONEWIRE_SLAVE_PRESENCE_EN
            // the classification cycle is already the first high cycle
            state_d   = PRES_WAIT;
            cnt_d     = W_ONE;
`endif
          end else begin
            err_d   = 1'b1;
            idx_d   = '0;
            shift_d = '0;
          end
        end else if (cnt_q != W_RST_MIN) begin
          cnt_d = cnt_q + W_ONE;
        end
      end
`ifdef ONEWIRE_SLAVE_PRESENCE_EN
      PRES_WAIT: begin
        if (bus_fall) begin
          state_d = MEAS;
          cnt_d   = W_ONE;
        end else if (cnt_q == W_PD_WAIT_M1) begin
          state_d = PRES_DRIVE;
          cnt_d   = W_ONE;
          pull_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + W_ONE;
        end
      end
      PRES_DRIVE: begin
        // our own low is never decoded; leave once the bus is released
        if (cnt_q != W_PD_LEN) begin
          cnt_d  = cnt_q + W_ONE;
          pull_d = 1'b1;
        end else if (bus_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      rst_det_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      rst_det_q    <= rst_det_d;
      err_q        <= err_d;
    end
  end

`ifdef ONEWIRE_SLAVE_PRESENCE_EN
  // presence drive register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pull_q <= 1'b0;
    else     pull_q <= pull_d;
  end
  assign bus_pull_low = pull_q;
`else
  assign bus_pull_low = 1'b0;
`endif

  assign bit_out    = bit_out_q;
  assign bit_valid  = bit_valid_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign rst_det    = rst_det_q;
  assign err        = err_q;

endmodule
